vga_scan_ctrl: RTL and testbench

- Display-side end of the pixel interface consumed by our on-screen blocks (menu, map view).
- Generates the raster scan position (hpos/vpos) that pixel sources decode, and samples their colour response after a fixed source latency.
- Drives registered, blanked RGB plus HSYNC/VSYNC to the DAC/connector, with sync and blanking delay-matched to the colour path.
- Also emits frame and line strobes that downstream logic uses to update state, such as latching map selection, between frames.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_delay_line.sv | 48 ++++
 rtl/vga_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, the control word carried beside the colour path,
// and small helpers for the VGA scan controller.
package vga_pkg;

  // Default 640x480@60 timing, in pixels and lines.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Position counters are 10 bits wide, so a total may not exceed this.
  localparam int unsigned POS_W   = 10;
  localparam int unsigned MAX_TOT = 1024;
  localparam int unsigned MAX_LAT = 4;

  // Sync and blanking travel together so they stay aligned with the colour.
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic active;
  } vga_ctrl_t;

  // Blanked, sync-inactive word used for reset of every stage.
  localparam vga_ctrl_t CTRL_IDLE = '{h_sync: 1'b0, v_sync: 1'b0, active: 1'b0};

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned chan_width(input int unsigned color_bits);
    return color_bits / 3;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with an asynchronous reset value. Used to
// delay the sync/active control word by the pixel-source latency.
module vga_delay_line #(
  parameter int unsigned     WIDTH     = 1,
  parameter int unsigned     DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_depth_err
    $error("vga_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Shift by one position on each enabled tick, otherwise hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (en_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers; reset loads the idle word everywhere.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan generator and display output stage. Produces hpos/vpos for the
// pixel sources, samples their colour SRC_LAT ticks later, and drives
// blanked RGB with sync/blank delay-matched to the colour path.
//
// Pixel tick: pix_en_i is a qualifier, not a handshake. A clk_i edge with
// pix_en_i high is one pixel; with it low nothing advances, every register
// holds and no strobe fires. There is no back-pressure.
module vga_scan_ctrl import vga_pkg::*; #(
  parameter int unsigned COLOR_BITS = 24,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned SRC_LAT    = 0,
  parameter logic        SYNC_ACT   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    pix_en_i,
  output logic [9:0]              hpos_o,
  output logic [9:0]              vpos_o,
  output logic                    active_o,
  output logic                    line_start_o,
  output logic                    frame_start_o,
  input  logic [COLOR_BITS/3-1:0] blue_i,
  input  logic [COLOR_BITS/3-1:0] green_i,
  input  logic [COLOR_BITS/3-1:0] red_i,
  output logic [COLOR_BITS/3-1:0] blue_o,
  output logic [COLOR_BITS/3-1:0] green_o,
  output logic [COLOR_BITS/3-1:0] red_o,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic                    blank_o
);

  localparam int unsigned CW      = chan_width(COLOR_BITS);
  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOT || V_TOTAL > MAX_TOT) begin : g_total_err
    $error("vga_scan_ctrl: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (SRC_LAT > MAX_LAT) begin : g_lat_err
    $error("vga_scan_ctrl: SRC_LAT must be 0..4");
  end

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_ACT    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_ACT    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [POS_W-1:0] hcnt_q, hcnt_d;
  logic [POS_W-1:0] vcnt_q, vcnt_d;
  vga_ctrl_t        ctrl_raw, ctrl_dly;
  logic [3*CW-1:0]  rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_q, blank_d;

  // Next scan position: horizontal wraps at the line end and carries into vertical.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en_i) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Undelayed sync/active decode of the current position.
  always_comb begin
    ctrl_raw        = CTRL_IDLE;
    ctrl_raw.h_sync = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
    ctrl_raw.v_sync = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
    ctrl_raw.active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  end

  // Match the control word to the source latency; zero latency needs no stage.
  if (SRC_LAT == 0) begin : g_no_delay
    assign ctrl_dly = ctrl_raw;
  end else begin : g_delay
    vga_delay_line #(
      .WIDTH     ($bits(vga_ctrl_t)),
      .DEPTH     (SRC_LAT),
      .RESET_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (pix_en_i),
      .d_i     (ctrl_raw),
      .q_o     (ctrl_dly)
    );
  end

  // Output stage: blank colour outside the active area, map sync polarity.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    blank_d = blank_q;
    if (pix_en_i) begin
      rgb_d   = ctrl_dly.active ? {blue_i, green_i, red_i} : '0;
      hsync_d = ctrl_dly.h_sync ? SYNC_ACT : ~SYNC_ACT;
      vsync_d = ctrl_dly.v_sync ? SYNC_ACT : ~SYNC_ACT;
      blank_d = ~ctrl_dly.active;
    end
  end

  // Output registers; reset presents a blanked, sync-inactive display.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rgb_q   <= '0;
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
      blank_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
    end
  end

  assign hpos_o        = hcnt_q;
  assign vpos_o        = vcnt_q;
  assign active_o      = ctrl_raw.active;
  assign line_start_o  = pix_en_i && (hcnt_q == '0);
  assign frame_start_o = pix_en_i && (hcnt_q == '0) && (vcnt_q == '0);
  assign blue_o        = rgb_q[3*CW-1 -: CW];
  assign green_o       = rgb_q[2*CW-1 -: CW];
  assign red_o         = rgb_q[CW-1:0];
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blank_o       = blank_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: three instances on a shrunken raster (32x12) with
// latencies 1, 3 and 0, checked every clock against a bench-side scan model.
module tb_vga_scan_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int W  = 27;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] b_in [3];
  logic [7:0] g_in [3];
  logic [7:0] r_in [3];
  logic [7:0] b_out [3];
  logic [7:0] g_out [3];
  logic [7:0] r_out [3];
  logic [9:0] hpos [3];
  logic [9:0] vpos [3];
  logic       active [3];
  logic       ls [3];
  logic       fs [3];
  logic       hs_o [3];
  logic       vs_o [3];
  logic       blank [3];

  vga_scan_ctrl #(.COLOR_BITS(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SRC_LAT(1), .SYNC_ACT(1'b0)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .pix_en_i(pix_en), .hpos_o(hpos[0]), .vpos_o(vpos[0]),
    .active_o(active[0]), .line_start_o(ls[0]), .frame_start_o(fs[0]),
    .blue_i(b_in[0]), .green_i(g_in[0]), .red_i(r_in[0]),
    .blue_o(b_out[0]), .green_o(g_out[0]), .red_o(r_out[0]),
    .hsync_o(hs_o[0]), .vsync_o(vs_o[0]), .blank_o(blank[0]));

  vga_scan_ctrl #(.COLOR_BITS(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SRC_LAT(3), .SYNC_ACT(1'b1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .pix_en_i(pix_en), .hpos_o(hpos[1]), .vpos_o(vpos[1]),
    .active_o(active[1]), .line_start_o(ls[1]), .frame_start_o(fs[1]),
    .blue_i(b_in[1]), .green_i(g_in[1]), .red_i(r_in[1]),
    .blue_o(b_out[1]), .green_o(g_out[1]), .red_o(r_out[1]),
    .hsync_o(hs_o[1]), .vsync_o(vs_o[1]), .blank_o(blank[1]));

  vga_scan_ctrl #(.COLOR_BITS(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SRC_LAT(0), .SYNC_ACT(1'b0)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .pix_en_i(pix_en), .hpos_o(hpos[2]), .vpos_o(vpos[2]),
    .active_o(active[2]), .line_start_o(ls[2]), .frame_start_o(fs[2]),
    .blue_i(b_in[2]), .green_i(g_in[2]), .red_i(r_in[2]),
    .blue_o(b_out[2]), .green_o(g_out[2]), .red_o(r_out[2]),
    .hsync_o(hs_o[2]), .vsync_o(vs_o[2]), .blank_o(blank[2]));

  // Scoreboard state
  logic [W-1:0]  exp_q0[$];
  logic [W-1:0]  exp_q1[$];
  logic [W-1:0]  exp_q2[$];
  logic [W-1:0]  last_out [3];
  logic [23:0]   col_hist[$];
  int            mh = 0, mv = 0;
  int            n_asserts = 0, n_fails = 0;
  int            fs_seen = 0, fs_model = 0;

  function automatic int lat_of(input int i);
    case (i)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic sa_of(input int i);
    return (i == 1);
  endfunction

  // Source colour for a position: non-zero everywhere, varies with hpos.
  function automatic logic [23:0] col_of(input int h, input int v);
    logic [7:0] b, g, r;
    b = 8'(h + 16);
    g = 8'(v * 3 + 1);
    r = 8'(h) ^ 8'h5A;
    return {b, g, r};
  endfunction

  function automatic logic [W-1:0] idle_word(input logic sa);
    return {24'h0, ~sa, ~sa, 1'b1};
  endfunction

  function automatic logic [W-1:0] exp_word(input int h, input int v, input logic sa);
    logic act, hr, vr;
    act = (h < HA) && (v < VA);
    hr  = (h >= HA + HF) && (h <= HA + HF + HS - 1);
    vr  = (v >= VA + VF) && (v <= VA + VF + VS - 1);
    return {act ? col_of(h, v) : 24'h0, hr ? sa : ~sa, vr ? sa : ~sa, ~act};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] w);
    case (i)
      0: exp_q0.push_back(w);
      1: exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [W-1:0] w, output bit ok);
    ok = 1'b1;
    w  = '0;
    case (i)
      0: if (exp_q0.size() > 0) w = exp_q0.pop_front(); else ok = 1'b0;
      1: if (exp_q1.size() > 0) w = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) w = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic logic [W-1:0] out_word(input int i);
    return {b_out[i], g_out[i], r_out[i], hs_o[i], vs_o[i], blank[i]};
  endfunction

  // Driver: one clk_i cycle with pix_en_i = en.
  task automatic step(input bit en);
    logic [W-1:0] w;
    logic [22:0]  exp_c;
    bit           ok;
    @(negedge clk);
    pix_en = en;
    if (en) begin
      col_hist.push_front(col_of(mh, mv));
      if (col_hist.size() > 5) void'(col_hist.pop_back());
    end
    for (int i = 0; i < 3; i++) begin
      if (en && col_hist.size() > lat_of(i))
        {b_in[i], g_in[i], r_in[i]} = col_hist[lat_of(i)];
      else
        {b_in[i], g_in[i], r_in[i]} = 24'($urandom);
    end
    #1;
    exp_c = {10'(mh), 10'(mv), (mh < HA) && (mv < VA), en && (mh == 0),
             en && (mh == 0) && (mv == 0)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("scan%0d", i), 64'({hpos[i], vpos[i], active[i], ls[i], fs[i]}), 64'(exp_c));
    end
    if (fs[0]) fs_seen++;
    if (en && mh == 0 && mv == 0) fs_model++;
    if (en) for (int i = 0; i < 3; i++) push_exp(i, exp_word(mh, mv, sa_of(i)));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (en) begin
        pop_exp(i, w, ok);
        if (!ok) chk($sformatf("queue_empty%0d", i), 64'(0), 64'(1));
        last_out[i] = w;
      end
      chk($sformatf("out%0d", i), 64'(out_word(i)), 64'(last_out[i]));
    end
    if (en) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  endtask

  // Asynchronous reset pulse and scoreboard restart.
  task automatic do_reset();
    @(negedge clk);
    pix_en = 1'b0;
    reset  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pos%0d", i), 64'({hpos[i], vpos[i], fs[i]}), 64'(21'h0));
      chk($sformatf("rst_out%0d", i), 64'(out_word(i)), 64'(idle_word(sa_of(i))));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_hold%0d", i), 64'(out_word(i)), 64'(idle_word(sa_of(i))));
    end
    @(negedge clk);
    reset = 1'b0;
    mh = 0;
    mv = 0;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    col_hist.delete();
    for (int i = 0; i < 3; i++) begin
      last_out[i] = idle_word(sa_of(i));
      for (int k = 0; k < lat_of(i); k++) push_exp(i, idle_word(sa_of(i)));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      b_in[i] = '0;
      g_in[i] = '0;
      r_in[i] = '0;
    end
    do_reset();

    // Two full frames with a constant pixel tick.
    for (int k = 0; k < 2 * HT * VT; k++) step(1'b1);

    // One frame's worth of ticks with pix_en_i every other clock.
    for (int k = 0; k < 2 * HT * VT; k++) step(k[0] == 1'b0);

    // Move to mid-frame and reset there; the next tick must start a frame.
    for (int k = 0; k < HT * VT && !(mh == 10 && mv == 3); k++) step(1'b1);
    chk("mid_pos", 64'({10'(mh), 10'(mv)}), 64'({10'd10, 10'd3}));
    do_reset();
    step(1'b1);

    // Irregular pixel tick.
    for (int k = 0; k < 1200; k++) step($urandom_range(0, 3) != 0);

    // Drain with steady ticks.
    for (int k = 0; k < 8; k++) step(1'b1);

    chk("frame_count", 64'(fs_seen), 64'(fs_model));
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
